// File: rtl/pwrseq_multi.sv
// pwrseq_multi: N-rail power sequencer with fault classification, bounded retry and latched lockout
module pwrseq_multi #(
    parameter int RAIL_COUNT    = 8,
    parameter int COUNTER_SIZE  = 20,
    parameter int T_MAX_WAIT    = 825000,
    parameter int T_DELAY_ON    = 4125,
    parameter int T_DELAY_OFF   = 4125,
    parameter int T_RETRY       = 412500,
    parameter int RETRY_MAX     = 2,
    parameter bit EN_ACTIVE_LOW = 1'b1
) (
    input  logic                  CLK_IN,
    input  logic                  RST_N,
    input  logic [RAIL_COUNT-1:0] PGOOD_A,
    input  logic                  SYSEN_A,
    input  logic                  FAULT_CLR,
    output logic [RAIL_COUNT-1:0] EN,
    output logic                  SYSGOOD,
    output logic                  FAULT,
    output logic [1:0]            FAULT_TYPE,
    output logic [3:0]            FAULT_RAIL,
    output logic [RAIL_COUNT-1:0] FAULT_PGOOD,
    output logic [1:0]            RETRY_CNT,
    output logic                  LOCKOUT,
    output logic [3:0]            STATE
);
    typedef enum logic [3:0] {
        S_OFF       = 4'd0,
        S_STEP_ON   = 4'd1,
        S_WAIT_PG   = 4'd2,
        S_DELAY_ON  = 4'd3,
        S_ON        = 4'd4,
        S_STEP_OFF  = 4'd5,
        S_DELAY_OFF = 4'd6,
        S_FAULT_OFF = 4'd7,
        S_HOLDOFF   = 4'd8,
        S_LOCKOUT   = 4'd9
    } state_t;

    localparam logic [COUNTER_SIZE-1:0] LIM_WAIT  = COUNTER_SIZE'(T_MAX_WAIT);
    localparam logic [COUNTER_SIZE-1:0] LIM_ON    = COUNTER_SIZE'(T_DELAY_ON);
    localparam logic [COUNTER_SIZE-1:0] LIM_OFF   = COUNTER_SIZE'(T_DELAY_OFF);
    localparam logic [COUNTER_SIZE-1:0] LIM_RETRY = COUNTER_SIZE'(T_RETRY);
    localparam logic [3:0]              LAST      = 4'(RAIL_COUNT - 1);
    localparam logic [1:0]              RMAX      = 2'(RETRY_MAX);

    state_t                  state, state_nx;
    logic [RAIL_COUNT-1:0]   pg_m, pg, en_r, idx_bit, lost;
    logic                    sys_m, sysen, pg_idx;
    logic [3:0]              idx, f_rail;
    logic [1:0]              f_type;
    logic [COUNTER_SIZE-1:0] timer;

    function automatic logic [3:0] lowest(input logic [RAIL_COUNT-1:0] m);
        lowest = '0;
        for (int i = RAIL_COUNT - 1; i >= 0; i--)
            if (m[i]) lowest = 4'(i);
    endfunction

    assign idx_bit = RAIL_COUNT'(1) << idx;
    assign pg_idx  = |(pg & idx_bit);
    // While waiting on rail IDX only the rails below it must already be good
    assign lost    = en_r & ~pg & ((state == S_WAIT_PG) ? idx_bit - RAIL_COUNT'(1) : '1);
    assign EN      = EN_ACTIVE_LOW ? ~en_r : en_r;
    assign LOCKOUT = state == S_LOCKOUT;
    assign STATE   = state;

    // Two-flop synchronisers for the asynchronous PGOOD and SYSEN inputs
    always_ff @(posedge CLK_IN or negedge RST_N)
        if (!RST_N) begin
            {pg, pg_m}     <= '0;
            {sysen, sys_m} <= '0;
        end else begin
            {pg, pg_m}     <= {pg_m, PGOOD_A};
            {sysen, sys_m} <= {sys_m, SYSEN_A};
        end

    // Next-state decode; a classified fault overrides every other transition
    always_comb begin
        state_nx = state;
        f_type   = 2'b00;
        f_rail   = '0;
        case (state)
            S_OFF:       if (sysen && !FAULT) state_nx = S_STEP_ON;
            S_STEP_ON:   state_nx = S_WAIT_PG;
            S_WAIT_PG:
                if (|lost) begin
                    f_type = 2'b10;
                    f_rail = lowest(lost);
                end else if (timer == LIM_WAIT && !pg_idx) begin
                    f_type = 2'b01;
                    f_rail = idx;
                end else if (pg_idx) state_nx = (idx == LAST) ? S_ON : S_DELAY_ON;
                else if (!sysen) state_nx = S_STEP_OFF;
            S_DELAY_ON:
                if (|lost) begin
                    f_type = 2'b10;
                    f_rail = lowest(lost);
                end else if (!sysen) state_nx = S_STEP_OFF;
                else if (timer == LIM_ON) state_nx = S_STEP_ON;
            S_ON:
                if (|lost) begin
                    f_type = 2'b11;
                    f_rail = lowest(lost);
                end else if (!sysen) state_nx = S_STEP_OFF;
            S_STEP_OFF:  state_nx = (idx == 4'd0) ? S_OFF : S_DELAY_OFF;
            S_DELAY_OFF: if (timer == LIM_OFF) state_nx = S_STEP_OFF;
            S_FAULT_OFF: if (en_r == '0) state_nx = (RETRY_CNT < RMAX) ? S_HOLDOFF : S_LOCKOUT;
            S_HOLDOFF:   state_nx = !sysen ? S_OFF : (timer == LIM_RETRY) ? S_STEP_ON : S_HOLDOFF;
            S_LOCKOUT:   if (FAULT_CLR && !sysen) state_nx = S_OFF;
            default:     state_nx = S_OFF;
        endcase
        if (f_type != 2'b00) state_nx = S_FAULT_OFF;
    end

    // State register and shared timer, cleared on every state change and saturating at all-ones
    always_ff @(posedge CLK_IN or negedge RST_N)
        if (!RST_N) begin
            state <= S_OFF;
            timer <= '0;
        end else begin
            state <= state_nx;
            timer <= (state_nx != state) ? '0 : (&timer) ? timer : timer + COUNTER_SIZE'(1);
        end

    // Rail index and enable vector; fault shutdown drops the top rail every cycle
    always_ff @(posedge CLK_IN or negedge RST_N)
        if (!RST_N) begin
            idx  <= '0;
            en_r <= '0;
        end else
            case (state)
                S_OFF, S_HOLDOFF: idx <= '0;
                S_STEP_ON:        en_r <= en_r | idx_bit;
                S_DELAY_ON:       if (state_nx == S_STEP_ON) idx <= idx + 4'd1;
                S_STEP_OFF, S_FAULT_OFF:
                    if (|en_r) begin
                        en_r <= en_r & ~idx_bit;
                        idx  <= (idx == 4'd0) ? idx : idx - 4'd1;
                    end
                S_LOCKOUT: begin
                    idx  <= '0;
                    en_r <= '0;
                end
                default: ;
            endcase

    // Fault record: the first classified fault is kept until an explicit clear
    always_ff @(posedge CLK_IN or negedge RST_N)
        if (!RST_N) begin
            FAULT       <= 1'b0;
            FAULT_TYPE  <= 2'b00;
            FAULT_RAIL  <= '0;
            FAULT_PGOOD <= '0;
        end else if ((state == S_LOCKOUT && state_nx == S_OFF) || (state == S_OFF && FAULT_CLR)) begin
            FAULT       <= 1'b0;
            FAULT_TYPE  <= 2'b00;
            FAULT_RAIL  <= '0;
            FAULT_PGOOD <= '0;
        end else if (f_type != 2'b00) begin
            FAULT <= 1'b1;
            if (FAULT_TYPE == 2'b00) begin
                FAULT_TYPE  <= f_type;
                FAULT_RAIL  <= f_rail;
                FAULT_PGOOD <= pg;
            end
        end else if (state == S_HOLDOFF && state_nx == S_STEP_ON) FAULT <= 1'b0;

    // Registered SYSGOOD and per-request retry counter
    always_ff @(posedge CLK_IN or negedge RST_N)
        if (!RST_N) begin
            SYSGOOD   <= 1'b0;
            RETRY_CNT <= 2'd0;
        end else begin
            SYSGOOD <= state == S_ON;
            if ((state == S_OFF && !sysen) || (state == S_LOCKOUT && state_nx == S_OFF)) RETRY_CNT <= 2'd0;
            else if (state == S_HOLDOFF && state_nx == S_STEP_ON && RETRY_CNT != RMAX) RETRY_CNT <= RETRY_CNT + 2'd1;
        end
endmodule

// File: tb/tb_pwrseq_multi.sv
// tb_pwrseq_multi: directed checks of power-up, shutdown, timeout retry, lockout and reset for pwrseq_multi
module tb_pwrseq_multi;
    localparam logic [3:0] S_OFF = 4'd0, S_STEP_ON = 4'd1, S_WAIT_PG = 4'd2, S_ON = 4'd4,
                           S_STEP_OFF = 4'd5, S_FAULT_OFF = 4'd7, S_HOLDOFF = 4'd8, S_LOCKOUT = 4'd9;

    logic       CLK_IN = 1'b0;
    logic       RST_N = 1'b0;
    logic       SYSEN_A = 1'b0;
    logic       FAULT_CLR = 1'b0;
    logic [3:0] PGOOD_A, EN, FAULT_PGOOD, FAULT_RAIL, STATE;
    logic [1:0] FAULT_TYPE, RETRY_CNT;
    logic       SYSGOOD, FAULT, LOCKOUT;

    logic [3:0]      stuck = 4'b0000;
    logic [3:0][2:0] cnt = '0;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int t0, t1;

    pwrseq_multi #(
        .RAIL_COUNT(4), .COUNTER_SIZE(8), .T_MAX_WAIT(20), .T_DELAY_ON(5),
        .T_DELAY_OFF(3), .T_RETRY(10), .RETRY_MAX(1), .EN_ACTIVE_LOW(1'b1)
    ) dut (
        .CLK_IN(CLK_IN), .RST_N(RST_N), .PGOOD_A(PGOOD_A), .SYSEN_A(SYSEN_A),
        .FAULT_CLR(FAULT_CLR), .EN(EN), .SYSGOOD(SYSGOOD), .FAULT(FAULT),
        .FAULT_TYPE(FAULT_TYPE), .FAULT_RAIL(FAULT_RAIL), .FAULT_PGOOD(FAULT_PGOOD),
        .RETRY_CNT(RETRY_CNT), .LOCKOUT(LOCKOUT), .STATE(STATE)
    );

    always #5 CLK_IN = ~CLK_IN;

    always @(posedge CLK_IN) cyc <= cyc + 1;

    // Rail model: PGOOD rises 4 cycles after its active-low EN falls, drops at once when EN releases
    always @(posedge CLK_IN)
        for (int k = 0; k < 4; k++)
            cnt[k] <= EN[k] ? 3'd0 : (cnt[k] == 3'd4) ? 3'd4 : cnt[k] + 3'd1;

    assign PGOOD_A = {cnt[3] == 3'd4, cnt[2] == 3'd4, cnt[1] == 3'd4, cnt[0] == 3'd4} & ~stuck;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK_IN);
        #1;
    endtask

    task automatic wait_en(input logic [3:0] v, input int budget, input string tag);
        int n = 0;
        while (EN !== v && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, EN, v);
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
        int n = 0;
        while (STATE !== s && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, STATE, s);
    endtask

    initial begin
        tick(2);
        chk("rst_en", EN, 4'b1111);
        chk("rst_state", STATE, S_OFF);
        chk("rst_flags", {SYSGOOD, FAULT, LOCKOUT}, 3'b000);
        chk("rst_record", {FAULT_TYPE, FAULT_RAIL, FAULT_PGOOD, RETRY_CNT}, 12'h000);
        RST_N = 1'b1;
        tick(2);

        // Power-up: rail gap = 4 PGOOD + 2 sync + 1 WAIT_PG + 6 DELAY_ON + 1 STEP_ON = 14
        SYSEN_A = 1'b1;
        wait_en(4'b1110, 20, "up_en0");
        t0 = cyc;
        chk("up_wait_state", STATE, S_WAIT_PG);
        wait_en(4'b1100, 40, "up_en1");
        chk("up_gap1", cyc - t0, 14);
        t0 = cyc;
        wait_en(4'b1000, 40, "up_en2");
        chk("up_gap2", cyc - t0, 14);
        t0 = cyc;
        wait_en(4'b0000, 40, "up_en3");
        chk("up_gap3", cyc - t0, 14);
        t0 = cyc;
        wait_state(S_ON, 40, "up_on");
        chk("up_on_lat", cyc - t0, 7);
        chk("up_sysgood_lag", SYSGOOD, 1'b0);
        tick(1);
        chk("up_sysgood", SYSGOOD, 1'b1);
        chk("up_fault", FAULT, 1'b0);

        // Orderly power-down: STEP_OFF plus four DELAY_OFF cycles between rail releases
        tick(3);
        SYSEN_A = 1'b0;
        wait_state(S_STEP_OFF, 10, "dn_step");
        chk("dn_sysgood_hold", SYSGOOD, 1'b1);
        tick(1);
        chk("dn_sysgood_drop", SYSGOOD, 1'b0);
        chk("dn_en3", EN, 4'b1000);
        t0 = cyc;
        wait_en(4'b1100, 20, "dn_en2");
        chk("dn_gap2", cyc - t0, 5);
        t0 = cyc;
        wait_en(4'b1110, 20, "dn_en1");
        chk("dn_gap1", cyc - t0, 5);
        t0 = cyc;
        wait_en(4'b1111, 20, "dn_en0");
        chk("dn_gap0", cyc - t0, 5);
        chk("dn_off", STATE, S_OFF);

        // Timeout on rail 2, one retry after hold-off, then lockout
        tick(3);
        stuck = 4'b0100;
        SYSEN_A = 1'b1;
        wait_en(4'b1000, 80, "to_en2");
        t0 = cyc;
        wait_state(S_FAULT_OFF, 40, "to_fault_state");
        chk("to_lat", cyc - t0, 21);
        chk("to_fault", FAULT, 1'b1);
        chk("to_type", FAULT_TYPE, 2'b01);
        chk("to_rail", FAULT_RAIL, 4'd2);
        chk("to_pgood", FAULT_PGOOD, 4'b0011);
        tick(1);
        chk("to_fast2", EN, 4'b1100);
        tick(1);
        chk("to_fast1", EN, 4'b1110);
        tick(1);
        chk("to_fast0", EN, 4'b1111);
        tick(1);
        chk("to_holdoff", STATE, S_HOLDOFF);
        t1 = cyc;
        wait_state(S_STEP_ON, 20, "to_retry");
        chk("to_holdoff_len", cyc - t1, 11);
        chk("to_retry_cnt", RETRY_CNT, 2'd1);
        chk("to_fault_clr", FAULT, 1'b0);
        chk("to_type_kept", FAULT_TYPE, 2'b01);
        wait_state(S_LOCKOUT, 200, "to_lockout_state");
        chk("to_lockout", LOCKOUT, 1'b1);
        chk("to_lockout_en", EN, 4'b1111);
        chk("to_lockout_rec", {FAULT, FAULT_TYPE, FAULT_RAIL}, {1'b1, 2'b01, 4'd2});

        // Lockout release needs FAULT_CLR together with SYSEN low
        FAULT_CLR = 1'b1;
        tick(1);
        FAULT_CLR = 1'b0;
        chk("lk_hold_state", STATE, S_LOCKOUT);
        chk("lk_hold_fault", FAULT, 1'b1);
        SYSEN_A = 1'b0;
        stuck = 4'b0000;
        tick(3);
        FAULT_CLR = 1'b1;
        tick(1);
        FAULT_CLR = 1'b0;
        chk("lk_rel_state", STATE, S_OFF);
        chk("lk_rel_lockout", LOCKOUT, 1'b0);
        chk("lk_rel_rec", {FAULT, FAULT_TYPE, FAULT_RAIL, FAULT_PGOOD, RETRY_CNT}, 13'h0000);

        // Rail 1 lost while ON with SYSEN dropping in the same cycle
        tick(2);
        SYSEN_A = 1'b1;
        wait_state(S_ON, 200, "lo_on");
        tick(2);
        stuck = 4'b0010;
        SYSEN_A = 1'b0;
        wait_state(S_FAULT_OFF, 10, "lo_fault_state");
        chk("lo_type", FAULT_TYPE, 2'b11);
        chk("lo_rail", FAULT_RAIL, 4'd1);
        chk("lo_pgood", FAULT_PGOOD, 4'b1101);
        tick(1);
        chk("lo_fast3", EN, 4'b1000);
        tick(1);
        chk("lo_fast2", EN, 4'b1100);
        tick(1);
        chk("lo_fast1", EN, 4'b1110);
        tick(1);
        chk("lo_fast0", EN, 4'b1111);
        wait_state(S_OFF, 20, "lo_off");
        chk("lo_rec_kept", {FAULT, FAULT_TYPE}, {1'b1, 2'b11});
        FAULT_CLR = 1'b1;
        tick(1);
        FAULT_CLR = 1'b0;
        chk("lo_cleared", {FAULT, FAULT_TYPE, FAULT_RAIL}, 7'h00);
        stuck = 4'b0000;

        // Asynchronous reset while waiting on rail 2
        tick(3);
        SYSEN_A = 1'b1;
        wait_en(4'b1000, 100, "ar_en2");
        chk("ar_wait_state", STATE, S_WAIT_PG);
        #2;
        RST_N = 1'b0;
        #1;
        chk("ar_en", EN, 4'b1111);
        chk("ar_state", STATE, S_OFF);
        chk("ar_outs", {SYSGOOD, FAULT, LOCKOUT, FAULT_TYPE, RETRY_CNT}, 7'h00);
        SYSEN_A = 1'b0;
        tick(2);
        RST_N = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
